// File: rtl/ds_window_avg.sv
// 2x2 box-filter downsampler: reads four pixels, writes their average.
// Define DS_ROUND_EN for round-half-up averaging; truncates otherwise.
module ds_window_avg #(
  parameter int ADDR_W = 18,
  parameter int DIM_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] R0   = 3'd1;
  localparam logic [2:0] R1   = 3'd2;
  localparam logic [2:0] R2   = 3'd3;
  localparam logic [2:0] R3   = 3'd4;
  localparam logic [2:0] R4   = 3'd5;
  localparam logic [2:0] WR   = 3'd6;
  localparam logic [2:0] FIN  = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] row_ptr_q, row_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic [DIM_W-1:0]  w_q, w_d;
  logic [DIM_W-1:0]  hw_q, hw_d;
  logic [DIM_W-1:0]  hh_q, hh_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [9:0]        acc_q, acc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] wz;
  logic [ADDR_W-1:0] a00;
  logic [9:0]        sum;
  logic [9:0]        rsum;
  logic [DIM_W-1:0]  col_nx;
  logic [DIM_W-1:0]  row_nx;
  logic              row_end;

  assign wz      = ADDR_W'(w_q);
  assign a00     = row_ptr_q + ADDR_W'(col_q);
  assign sum     = acc_q + {2'b00, mem_rdata};
  assign col_nx  = col_q + DIM_W'(2);
  assign row_nx  = row_q + DIM_W'(1);
  assign row_end = (col_nx >> 1) == hw_q;

`ifdef DS_ROUND_EN
  assign rsum = sum + 10'd2;
`else
  assign rsum = sum;
`endif

  always_comb begin
    state_d   = state_q;
    row_ptr_d = row_ptr_q;
    dst_ptr_d = dst_ptr_q;
    w_d       = w_q;
    hw_d      = hw_q;
    hh_d      = hh_q;
    col_d     = col_q;
    row_d     = row_q;
    acc_d     = acc_q;
    addr_d    = addr_q;
    we_d      = 1'b0;
    wdata_d   = wdata_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          row_ptr_d = src_base;
          dst_ptr_d = dst_base;
          w_d       = img_w;
          hw_d      = img_w >> 1;
          hh_d      = img_h >> 1;
          col_d     = '0;
          row_d     = '0;
          acc_d     = '0;
          busy_d    = 1'b1;
          if ((img_w >> 1) == '0 || (img_h >> 1) == '0) begin
            state_d = FIN;
          end else begin
            state_d = R0;
            addr_d  = src_base;
          end
        end
      end
      R0: begin
        addr_d  = a00 + ADDR_W'(1);
        state_d = R1;
      end
      R1: begin
        acc_d   = sum;
        addr_d  = a00 + wz;
        state_d = R2;
      end
      R2: begin
        acc_d   = sum;
        addr_d  = a00 + wz + ADDR_W'(1);
        state_d = R3;
      end
      R3: begin
        acc_d   = sum;
        state_d = R4;
      end
      R4: begin
        acc_d   = sum;
        we_d    = 1'b1;
        addr_d  = dst_ptr_q;
        wdata_d = rsum[9:2];
        state_d = WR;
      end
      WR: begin
        col_d     = col_nx;
        dst_ptr_d = dst_ptr_q + ADDR_W'(1);
        // Row pointer steps by two source rows; no multiply needed.
        if (row_end) begin
          col_d     = '0;
          row_ptr_d = row_ptr_q + (wz << 1);
          row_d     = row_nx;
        end
        if (row_end && row_nx == hh_q) begin
          state_d = FIN;
        end else begin
          state_d = R0;
          acc_d   = '0;
          addr_d  = row_ptr_d + ADDR_W'(col_d);
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_ptr_q <= '0;
      dst_ptr_q <= '0;
      w_q       <= '0;
      hw_q      <= '0;
      hh_q      <= '0;
      col_q     <= '0;
      row_q     <= '0;
      acc_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_ptr_q <= row_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      w_q       <= w_d;
      hw_q      <= hw_d;
      hh_q      <= hh_d;
      col_q     <= col_d;
      row_q     <= row_d;
      acc_q     <= acc_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
